fft_bfly_agu: RTL
=================

FFT_BFLY_AGU -- requirements
Module: fft_bfly_agu

Interface
REQ-001 The block SHALL have a parameter N_LOG2, default 5, meaning log2 of the FFT size N; legal range 2..10.
REQ-002 The block SHALL have a parameter WB_LAT, default 2, meaning butterfly-to-writeback latency in cycles; legal range 1..8.
REQ-003 One clock; reset is synchronous and active-high. Clock port: clk. Reset port: rst.
REQ-004 Ports SHALL be:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; begins one full radix-2 DIT pass
- out_ready  input  1  butterfly datapath accepts current operand request
- out_valid  output  1  addr_a, addr_b, tw_addr and stage are valid
- addr_a  output  N_LOG2  memory address of butterfly input A
- addr_b  output  N_LOG2  memory address of butterfly input B
- tw_addr  output  N_LOG2-1  twiddle ROM index
- stage  output  4  current stage index s
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse at pass completion
- wr_en  output  1  writeback strobe (macro-dependent, REQ-019)
- wr_addr_a  output  N_LOG2  writeback address for X
- wr_addr_b  output  N_LOG2  writeback address for Y

Function
REQ-005 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-006 IDLE->RUN on start=1; s=0, k=0 loaded; out_valid=1 on the next cycle.
REQ-007 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-008 For stage s and butterfly index k (0..N/2-1), with half=2^s, group=k>>s, pos=k&(half-1):
- addr_a = group*2*half + pos
- addr_b = addr_a + half
- tw_addr = pos<<(N_LOG2-1-s)
REQ-009 A handshake SHALL occur on a cycle with out_valid=1 and out_ready=1; k then advances by 1.
REQ-010 When out_ready=0, addr_a, addr_b, tw_addr and stage SHALL hold stable.
REQ-011 At k=N/2-1 with a handshake, k wraps to 0 and s increments; no bubble between stages.
REQ-012 On the handshake at s=N_LOG2-1, k=N/2-1, out_valid SHALL deassert the next cycle and the FSM SHALL enter DRAIN, or DONE when the macro is absent.
REQ-013 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-014 busy=1 in RUN and DRAIN; busy=0 in IDLE and DONE.
REQ-015 A full pass SHALL issue exactly (N/2)*N_LOG2 handshakes.
REQ-016 A start arriving in the DONE cycle SHALL be ignored.

Reset
REQ-017 rst=1 SHALL force IDLE, s=0, k=0 and clear the writeback pipeline. All outputs SHALL read 0: out_valid, busy, done, wr_en, addr_a, addr_b, tw_addr, stage, wr_addr_a, wr_addr_b.
REQ-018 rst asserted mid-pass SHALL abort the pass with no done pulse; rst takes priority over start.

Configuration
REQ-019 Macro FFT_AGU_WRITEBACK_EN SHALL control the writeback pipeline.
- Defined: a WB_LAT-deep shift register carries {addr_a, addr_b} per handshake. wr_en=1 exactly WB_LAT cycles after each handshake, with the matching addresses.
- Defined: DRAIN lasts until the last wr_en has been issued; done is asserted the cycle after that last wr_en.
- Undefined: wr_en, wr_addr_a and wr_addr_b are tied to 0, DRAIN is unreachable, and DONE follows the last handshake directly.

Verification
REQ-020 N_LOG2=3, start, out_ready=1 constantly -> (a,b,tw) sequence:
- s0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
- s1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
- s2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- then 12 handshakes total and one done pulse.
REQ-021 Macro defined, N_LOG2=3, WB_LAT=2, out_ready=1 -> 12 wr_en pulses, each 2 cycles after its handshake with identical addresses; done is 1 cycle after the 12th wr_en.
REQ-022 out_ready held 0 for 5 cycles at s=1, k=1 -> outputs hold (1,3,2,stage=1); the sequence resumes unchanged on release.
REQ-023 start pulsed at s=2, k=0 mid-pass -> ignored; the pass completes with exactly 12 handshakes and one done.
REQ-024 rst pulsed at s=1, k=2 -> next cycle all outputs 0 and state IDLE with no done; a new start restarts at (0,1,0).
REQ-025 N_LOG2=2 boundary -> (0,1,0) (2,3,0) (0,2,0) (1,3,1), then done.

Source files
------------

// File: rtl/fft_bfly_agu.sv
// rtl/fft_bfly_agu.sv - radix-2 DIT butterfly address generator with optional writeback pipeline
// Optional writeback pipeline enabled by defining FFT_AGU_WRITEBACK_EN.
module fft_bfly_agu #(
    parameter int N_LOG2 = 5,
    parameter int WB_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_addr,
    output logic [3:0]        stage,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int         KW     = N_LOG2 - 1;
    localparam logic [3:0] LAST_S = 4'(N_LOG2 - 1);

    if (N_LOG2 < 2 || N_LOG2 > 10 || WB_LAT < 1 || WB_LAT > 8) begin : g_param_check
        $error("fft_bfly_agu: N_LOG2 or WB_LAT out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [3:0]        s_q;
    logic [KW-1:0]     k_q;
    logic              out_valid_q;
    logic [N_LOG2-1:0] addr_a_q;
    logic [N_LOG2-1:0] addr_b_q;
    logic [KW-1:0]     tw_q;
    logic              busy_q;
    logic              done_q;

    logic [3:0]        s_d;
    logic [KW-1:0]     k_d;
    logic [N_LOG2-1:0] a_d;
    logic [N_LOG2-1:0] b_d;
    logic [KW-1:0]     tw_d;
    logic              hs;
    logic              last;
    logic              drain_fin;

    // group*2*half + pos: the bits of k above s move up one place, bit s becomes 0
    function automatic logic [N_LOG2-1:0] lo_addr(input logic [3:0] s, input logic [KW-1:0] k);
        logic [N_LOG2-1:0] kx;
        logic [N_LOG2-1:0] mask;
        kx   = {1'b0, k};
        mask = (N_LOG2'(1) << s) - N_LOG2'(1);
        return ((kx & ~mask) << 1) | (kx & mask);
    endfunction

    function automatic logic [KW-1:0] tw_index(input logic [3:0] s, input logic [KW-1:0] k);
        logic [KW-1:0] mask;
        mask = KW'((N_LOG2'(1) << s) - N_LOG2'(1));
        return (k & mask) << (4'(KW) - s);
    endfunction

    assign hs   = out_valid_q & out_ready;
    assign last = (s_q == LAST_S) && (k_q == '1);

    // Next butterfly; outside RUN this is the first butterfly of a pass
    always_comb begin
        s_d = '0;
        k_d = '0;
        if (state_q == ST_RUN) begin
            k_d = k_q + KW'(1);
            s_d = (k_q == '1) ? s_q + 4'd1 : s_q;
        end
        a_d  = lo_addr(s_d, k_d);
        b_d  = a_d | (N_LOG2'(1) << s_d);
        tw_d = tw_index(s_d, k_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            tw_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        s_q         <= s_d;
                        k_q         <= k_d;
                        addr_a_q    <= a_d;
                        addr_b_q    <= b_d;
                        tw_q        <= tw_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (last) begin
                            out_valid_q <= 1'b0;
                            s_q         <= '0;
                            k_q         <= '0;
                            addr_a_q    <= '0;
                            addr_b_q    <= '0;
                            tw_q        <= '0;
`ifdef FFT_AGU_WRITEBACK_EN
                            state_q     <= ST_DRAIN;
`else
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
`endif
                        end else begin
                            s_q      <= s_d;
                            k_q      <= k_d;
                            addr_a_q <= a_d;
                            addr_b_q <= b_d;
                            tw_q     <= tw_d;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_fin) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FFT_AGU_WRITEBACK_EN
    logic [WB_LAT-1:0] wb_v_q;
    logic [N_LOG2-1:0] wb_a_q [WB_LAT];
    logic [N_LOG2-1:0] wb_b_q [WB_LAT];
    logic              wb_pending;

    // Empty slots carry zero addresses so wr_addr_* read 0 whenever wr_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v_q <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                wb_a_q[i] <= '0;
                wb_b_q[i] <= '0;
            end
        end else begin
            wb_v_q[0] <= hs;
            wb_a_q[0] <= hs ? addr_a_q : '0;
            wb_b_q[0] <= hs ? addr_b_q : '0;
            for (int i = 1; i < WB_LAT; i++) begin
                wb_v_q[i] <= wb_v_q[i-1];
                wb_a_q[i] <= wb_a_q[i-1];
                wb_b_q[i] <= wb_b_q[i-1];
            end
        end
    end

    always_comb begin
        wb_pending = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++) begin
            wb_pending = wb_pending | wb_v_q[i];
        end
    end

    assign drain_fin = wb_v_q[WB_LAT-1] & ~wb_pending;
    assign wr_en     = wb_v_q[WB_LAT-1];
    assign wr_addr_a = wb_a_q[WB_LAT-1];
    assign wr_addr_b = wb_b_q[WB_LAT-1];
`else
    assign drain_fin = 1'b0;
    assign wr_en     = 1'b0;
    assign wr_addr_a = '0;
    assign wr_addr_b = '0;
`endif

    assign out_valid = out_valid_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign tw_addr   = tw_q;
    assign stage     = s_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
